// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
//   Shared definitions for the MIPS fetch stage:
//     - NOP encoding written into IF/ID as a bubble
//     - fetch state encodings (2 bits, legacy-compatible constants)
//     - default reset PC
//     - small helpers for word alignment and misalignment detection
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

  // All-zero word is "sll $0,$0,0", the canonical MIPS NOP.
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Fetch state encodings.
  localparam logic [1:0] FS_BOOT   = 2'd0;
  localparam logic [1:0] FS_RUN    = 2'd1;
  localparam logic [1:0] FS_HALTED = 2'd2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] byte_addr);
    return {byte_addr[31:2], 2'b00};
  endfunction

  // A redirect target is misaligned when its low two bits are non-zero.
  function automatic logic is_misaligned(input logic [31:0] byte_addr);
    return |byte_addr[1:0];
  endfunction

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register. Three mutually exclusive actions per edge:
//     bubble : instr <= NOP, valid <= 0, pc/pc_plus4 keep their old values
//     load   : capture next_pc, next_pc_plus4, next_instr, valid <= 1
//     (none) : hold everything
//   bubble wins if both controls are raised.
//
// Ports
//   clk            in   1           rising-edge clock
//   reset          in   1           synchronous, active-high reset
//   load           in   1           capture a fetched instruction
//   bubble         in   1           insert a bubble
//   next_pc        in   32          PC of the instruction being captured
//   next_pc_plus4  in   32          next_pc + 4
//   next_instr     in   DATA_WIDTH  instruction word being captured
//   pc             out  32          PC of the held instruction
//   pc_plus4       out  32          pc + 4 of the held instruction
//   instr          out  DATA_WIDTH  held instruction
//   valid          out  1           held instruction is real (not a bubble)
// -----------------------------------------------------------------------------
module if_id_reg
  import instruction_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  bubble,
  input  logic [31:0]           next_pc,
  input  logic [31:0]           next_pc_plus4,
  input  logic [DATA_WIDTH-1:0] next_instr,
  output logic [31:0]           pc,
  output logic [31:0]           pc_plus4,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  valid
);

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= 32'h0;
      pc_plus4 <= 32'h0;
      instr    <= DATA_WIDTH'(NOP);
      valid    <= 1'b0;
    end else if (bubble) begin
      // pc/pc_plus4 deliberately retained: decode may still want the last
      // real PC for exception reporting.
      instr <= DATA_WIDTH'(NOP);
      valid <= 1'b0;
    end else if (load) begin
      pc       <= next_pc;
      pc_plus4 <= next_pc_plus4;
      instr    <= next_instr;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Fetch stage of the MIPS pipeline. Owns the PC, drives the word address to
//   an asynchronous-read instruction memory, and captures the returned word
//   together with its PC into the IF/ID register (if_id_reg).
//
//   Per-edge priority while running: redirect > halt > stall > flush > normal.
//   A redirect drops the wrong-path fetch even when stall is asserted.
//   After reset one BOOT cycle inserts a bubble with the PC held; HALTED
//   freezes the PC and inserts bubbles until reset.
//
//   Optional feature: define IF_PERF_CNT_EN to add perf_fetched / perf_stall
//   counters and their output ports.
//
// Ports
//   clk            in   1           rising-edge clock
//   reset          in   1           synchronous, active-high reset
//   stall          in   1           hold PC and IF/ID
//   flush          in   1           bubble into IF/ID, PC advances
//   redirect_valid in   1           taken branch/jump this cycle
//   redirect_pc    in   32          byte target; bits [1:0] ignored
//   halt_req       in   1           stop fetching
//   imem_addr      out  ADDR_WIDTH  word address (pc[ADDR_WIDTH+1:2])
//   imem_data      in   DATA_WIDTH  instruction returned in the same cycle
//   if_pc          out  32          PC of instruction in IF/ID
//   if_pc_plus4    out  32          if_pc + 4
//   if_instr       out  DATA_WIDTH  instruction in IF/ID
//   if_valid       out  1           IF/ID holds a real instruction
//   redirect_misal out  1           sticky: some redirect target was misaligned
//   halted         out  1           fetch is halted
//   perf_fetched   out  32          (IF_PERF_CNT_EN) valid writes into IF/ID
//   perf_stall     out  32          (IF_PERF_CNT_EN) running edges stalled
// -----------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 6,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  halt_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [31:0]           if_pc,
  output logic [31:0]           if_pc_plus4,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  if_valid,
  output logic                  redirect_misal,
  output logic                  halted
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  logic [1:0]  state, state_next;
  logic [31:0] pc, pc_next, pc_plus4;
  logic        ifid_load, ifid_bubble;
  logic        set_misal;

  assign pc_plus4 = pc + 32'd4;

  // Truncation is intentional: PCs past the last word alias back to word 0.
  assign imem_addr = pc[ADDR_WIDTH+1:2];
  assign halted    = (state == FS_HALTED);

  // ---------------------------------------------------------------------------
  // Next-state / control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    set_misal   = 1'b0;

    case (state)
      FS_BOOT: begin
        state_next  = FS_RUN;
        ifid_bubble = 1'b1;
      end

      FS_RUN: begin
        if (redirect_valid) begin
          // Whatever was fetched this cycle is wrong-path; drop it.
          pc_next     = word_align(redirect_pc);
          ifid_bubble = 1'b1;
          set_misal   = is_misaligned(redirect_pc);
        end else if (halt_req) begin
          state_next  = FS_HALTED;
          ifid_bubble = 1'b1;
        end else if (stall) begin
          // Hold PC and IF/ID; a simultaneous flush is ignored.
        end else if (flush) begin
          ifid_bubble = 1'b1;
          pc_next     = pc_plus4;
        end else begin
          ifid_load = 1'b1;
          pc_next   = pc_plus4;
        end
      end

      FS_HALTED: begin
        ifid_bubble = 1'b1;
      end

      default: begin
        // Unreachable encoding: restart cleanly through BOOT.
        state_next  = FS_BOOT;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // PC, FSM state and sticky misalignment flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FS_BOOT;
      pc             <= RESET_PC;
      redirect_misal <= 1'b0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (set_misal) begin
        redirect_misal <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register
  // ---------------------------------------------------------------------------
  if_id_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .load          (ifid_load),
    .bubble        (ifid_bubble),
    .next_pc       (pc),
    .next_pc_plus4 (pc_plus4),
    .next_instr    (imem_data),
    .pc            (if_pc),
    .pc_plus4      (if_pc_plus4),
    .instr         (if_instr),
    .valid         (if_valid)
  );

`ifdef IF_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap at 2**32)
  // ---------------------------------------------------------------------------
  logic stall_edge;

  // Counts stalled running edges even when halt_req wins that edge.
  assign stall_edge = (state == FS_RUN) && stall && !redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'h0;
      perf_stall   <= 32'h0;
    end else begin
      if (ifid_load) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (stall_edge) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. A behavioural model of the fetch
//   stage (plain PC arithmetic, a booting/halted flag pair, an IF/ID snapshot)
//   advances on every rising edge; a compare process checks all DUT outputs
//   against it on every falling edge. Directed sequences with literal
//   expectations come first, then a long randomized run.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int ADDR_WIDTH = 6;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  stall;
  logic                  flush;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  halt_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic [31:0]           if_pc;
  logic [31:0]           if_pc_plus4;
  logic [DATA_WIDTH-1:0] if_instr;
  logic                  if_valid;
  logic                  redirect_misal;
  logic                  halted;
`ifdef IF_PERF_CNT_EN
  logic [31:0]           perf_fetched;
  logic [31:0]           perf_stall;
`endif

  logic [31:0] mem [DEPTH];
  assign imem_data = mem[imem_addr];

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .if_instr       (if_instr),
    .if_valid       (if_valid),
    .redirect_misal (redirect_misal),
    .halted         (halted)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_pc, m_if_pc, m_if_pc4, m_instr;
  bit          m_booting, m_halted, m_valid, m_misal;
  int unsigned m_fetched, m_stalls;

  always @(posedge clk) begin
    if (reset) begin
      m_pc = 32'h0; m_booting = 1; m_halted = 0;
      m_if_pc = 0; m_if_pc4 = 0; m_instr = 0; m_valid = 0; m_misal = 0;
      m_fetched = 0; m_stalls = 0;
    end else if (m_booting) begin
      m_booting = 0; m_instr = 0; m_valid = 0;
    end else if (m_halted) begin
      m_instr = 0; m_valid = 0;
    end else if (redirect_valid) begin
      if (redirect_pc % 4 != 0) m_misal = 1;
      m_pc = redirect_pc - (redirect_pc % 4);
      m_instr = 0; m_valid = 0;
    end else begin
      if (stall) m_stalls++;
      if (halt_req) begin
        m_halted = 1; m_instr = 0; m_valid = 0;
      end else if (stall) begin
        // everything holds
      end else if (flush) begin
        m_instr = 0; m_valid = 0; m_pc = m_pc + 4;
      end else begin
        m_if_pc = m_pc; m_if_pc4 = m_pc + 4;
        m_instr = mem[(m_pc / 4) % DEPTH];
        m_valid = 1; m_fetched++;
        m_pc = m_pc + 4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process: every falling edge once the model is initialised
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("imem_addr",      32'(imem_addr), (m_pc / 4) % DEPTH);
      check("if_pc",          if_pc,          m_if_pc);
      check("if_pc_plus4",    if_pc_plus4,    m_if_pc4);
      check("if_instr",       if_instr,       m_instr);
      check("if_valid",       32'(if_valid),  32'(m_valid));
      check("redirect_misal", 32'(redirect_misal), 32'(m_misal));
      check("halted",         32'(halted),    32'(m_halted));
`ifdef IF_PERF_CNT_EN
      check("perf_fetched",   perf_fetched,   m_fetched);
      check("perf_stall",     perf_stall,     m_stalls);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0; halt_req = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    idle_inputs();
    reset = 1;
    tick(); tick();
    chk_en = 1;

    // Reset state
    check("rst_valid",  32'(if_valid), 0);
    check("rst_pc",     if_pc, 0);
    check("rst_instr",  if_instr, 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_addr",   32'(imem_addr), 0);

    // 1: BOOT bubble, then sequential fetch
    reset = 0;
    tick();
    check("boot_valid", 32'(if_valid), 0);
    check("boot_addr",  32'(imem_addr), 0);
    tick();
    check("f0_instr", if_instr, 32'h1000_0000);
    check("f0_pc",    if_pc, 32'h0);
    check("f0_pc4",   if_pc_plus4, 32'h4);
    check("f0_valid", 32'(if_valid), 1);
    tick();
    check("f1_instr", if_instr, 32'h1000_0001);
    check("f1_pc",    if_pc, 32'h4);

    // 2: stall for three edges with pc=8
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 32'(imem_addr), 2);
      check("stall_pc",   if_pc, 32'h4);
    end
    stall = 0;
    tick();
    check("unstall_pc",    if_pc, 32'h8);
    check("unstall_instr", if_instr, 32'h1000_0002);

    // 3: redirect wins over stall
    redirect_valid = 1; redirect_pc = 32'h20; stall = 1;
    tick();
    check("redir_valid", 32'(if_valid), 0);
    check("redir_addr",  32'(imem_addr), 8);
    idle_inputs();
    tick();
    check("redir_pc",    if_pc, 32'h20);
    check("redir_instr", if_instr, 32'h1000_0008);

    // 4: misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h23;
    tick();
    check("misal_addr", 32'(imem_addr), 8);
    check("misal_flag", 32'(redirect_misal), 1);
    idle_inputs();
    tick();
    check("misal_pc",     if_pc, 32'h20);
    check("misal_sticky", 32'(redirect_misal), 1);

    // flush bubbles but advances; flush with stall is ignored
    flush = 1;
    tick();
    check("flush_valid", 32'(if_valid), 0);
    check("flush_pc",    if_pc, 32'h20);
    check("flush_addr",  32'(imem_addr), 10);
    stall = 1;
    tick();
    check("flush_stall_addr", 32'(imem_addr), 10);
    idle_inputs();

    // 5: wrap of the word address past the last word
    redirect_valid = 1; redirect_pc = 32'hFC;
    tick();
    check("wrap_addr63", 32'(imem_addr), 63);
    idle_inputs();
    tick();
    check("wrap_instr63", if_instr, 32'h1000_003F);
    check("wrap_addr0",   32'(imem_addr), 0);
    tick();
    check("wrap_pc100",   if_pc, 32'h100);
    check("wrap_pc4",     if_pc_plus4, 32'h104);
    check("wrap_instr0",  if_instr, 32'h1000_0000);

    // 6: halt at pc=12, then only reset releases it
    reset = 1; tick(); reset = 0;
    check("rst2_misal", 32'(redirect_misal), 0);
    tick(); tick(); tick(); tick();
    check("pre_halt_addr", 32'(imem_addr), 3);
`ifdef IF_PERF_CNT_EN
    check("pre_halt_fetched", perf_fetched, 3);
    check("pre_halt_stall",   perf_stall, 0);
`endif
    halt_req = 1;
    tick();
    check("halt_flag",  32'(halted), 1);
    check("halt_valid", 32'(if_valid), 0);
    for (int i = 0; i < 6; i++) begin
      stall = 1'($urandom); flush = 1'($urandom); halt_req = 1'($urandom);
      redirect_valid = 1'($urandom); redirect_pc = $urandom;
      tick();
      check("halted_addr",  32'(imem_addr), 3);
      check("halted_valid", 32'(if_valid), 0);
      check("halted_flag",  32'(halted), 1);
    end
    idle_inputs();
    reset = 1; tick(); reset = 0;
    check("unhalt_flag", 32'(halted), 0);
    check("unhalt_addr", 32'(imem_addr), 0);

    // Randomized run against the model
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(0, 99) == 0);
      halt_req       = ($urandom_range(0, 59) == 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
      stall          = ($urandom_range(0, 3) == 0);
      flush          = ($urandom_range(0, 5) == 0);
      tick();
    end
    idle_inputs();
    reset = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
